// File: rtl/busca_instrucao.sv
`default_nettype none
// ============================================================================
//  Module     : busca_instrucao
//  Description: Instruction fetch/sequencing unit. Fetches 8-bit words into
//               the IR, feeds the control decoder, and updates the PC from
//               the decoder's Jump/Halt/Beqz flags.
//  Revision   : 1.0 - initial release
// ============================================================================
module busca_instrucao #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 16,
    parameter int              CNT_W    = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inicio,
    output logic [PC_W-1:0]  mem_endereco,
    output logic             mem_req,
    input  logic [7:0]       mem_dado,
    input  logic             mem_valido,
    output logic [7:0]       instrucao,
    output logic [2:0]       OPcode,
    output logic [1:0]       BitVerificao,
    input  logic             Jump,
    input  logic             Halt,
    input  logic             Beqz,
    input  logic             zero,
    input  logic [PC_W-1:0]  alvo,
    output logic [PC_W-1:0]  pc,
    output logic             ocupado,
    output logic             parado,
    output logic             erro,
    output logic [CNT_W-1:0] instr_contador
);

    localparam int                c_ESPERA_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_ESPERA_W-1:0] c_ESPERA_ULTIMA = c_ESPERA_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        c_OCIOSO     = 3'd0,
        c_BUSCA      = 3'd1,
        c_ESPERA     = 3'd2,
        c_DECODIFICA = 3'd3,
        c_EXECUTA    = 3'd4,
        c_PARADO     = 3'd5,
        c_ERRO       = 3'd6
    } estado_t;

    estado_t                 r_estado;
    estado_t                 w_prox;
    logic [PC_W-1:0]         r_pc;
    logic [PC_W-1:0]         w_pc_prox;
    logic [7:0]              r_ir;
    logic [c_ESPERA_W-1:0]   r_espera;
    logic [CNT_W-1:0]        r_contador;
    logic [CNT_W-1:0]        w_contador_prox;
    logic                    r_mem_req;
    logic                    r_ocupado;
    logic                    r_parado;
    logic                    r_erro;

    always_comb begin
        w_prox = r_estado;
        case (r_estado)
            c_OCIOSO:     if (inicio) w_prox = c_BUSCA;
            c_BUSCA:      w_prox = c_ESPERA;
            c_ESPERA: begin
                // A word arriving on the final wait cycle still beats the timeout.
                if (mem_valido)
                    w_prox = c_DECODIFICA;
                else if (r_espera == c_ESPERA_ULTIMA)
                    w_prox = c_ERRO;
            end
            c_DECODIFICA: w_prox = c_EXECUTA;
            c_EXECUTA:    w_prox = Halt ? c_PARADO : c_BUSCA;
            c_PARADO:     w_prox = c_PARADO;
            c_ERRO:       w_prox = c_ERRO;
            default:      w_prox = c_OCIOSO;
        endcase
    end

    always_comb begin
        w_pc_prox = r_pc + PC_W'(1);
        if (Halt)
            w_pc_prox = r_pc;
        else if (Jump || (Beqz && zero))
            w_pc_prox = alvo;
    end

    always_comb begin
        w_contador_prox = r_contador;
        if (r_contador != {CNT_W{1'b1}})
            w_contador_prox = r_contador + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_estado   <= c_OCIOSO;
            r_pc       <= RESET_PC;
            r_ir       <= 8'h00;
            r_espera   <= '0;
            r_contador <= '0;
            r_mem_req  <= 1'b0;
            r_ocupado  <= 1'b0;
            r_parado   <= 1'b0;
            r_erro     <= 1'b0;
        end else begin
            r_estado <= w_prox;
            // Status outputs are registered from the next state so they line up with r_estado.
            r_mem_req <= (w_prox == c_BUSCA);
            r_ocupado <= (w_prox == c_BUSCA) || (w_prox == c_ESPERA) ||
                         (w_prox == c_DECODIFICA) || (w_prox == c_EXECUTA);
            r_parado  <= (w_prox == c_PARADO);
            r_erro    <= (w_prox == c_ERRO);

            case (r_estado)
                c_BUSCA: r_espera <= '0;
                c_ESPERA: begin
                    if (mem_valido)
                        r_ir <= mem_dado;
                    else if (r_espera != c_ESPERA_ULTIMA)
                        r_espera <= r_espera + c_ESPERA_W'(1);
                end
                c_EXECUTA: begin
                    r_pc       <= w_pc_prox;
                    r_contador <= w_contador_prox;
                end
                default: ;
            endcase
        end
    end

    assign mem_endereco   = r_pc;
    assign pc             = r_pc;
    assign mem_req        = r_mem_req;
    assign instrucao      = r_ir;
    assign OPcode         = r_ir[7:5];
    assign BitVerificao   = r_ir[1:0];
    assign ocupado        = r_ocupado;
    assign parado         = r_parado;
    assign erro           = r_erro;
    assign instr_contador = r_contador;

endmodule
`default_nettype wire
